// File: rtl/puf_pkg.sv
// Shared types and default parameters for the PUF evaluation controller.
package puf_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_RELAX = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam int DEF_NUM_EVALS      = 5;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int DEF_RELAX_CYCLES   = 4;
    localparam int PUF_W              = 8;

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module puf_sync2 (
    input  logic clk,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/puf_eval_controller.sv
// PUF evaluation controller: repeated evaluations with timeout and relax gap.
// Define PUF_MAJORITY_VOTE_EN for NUM_EVALS-way majority voting.
module puf_eval_controller
    import puf_pkg::*;
#(
    parameter int NUM_EVALS      = DEF_NUM_EVALS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RELAX_CYCLES   = DEF_RELAX_CYCLES
) (
    input  logic             clk,
    input  logic             computer_reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PUF_W-1:0] req_challenge,
    output logic             puf_enable,
    output logic [PUF_W-1:0] puf_challenge,
    input  logic [PUF_W-1:0] puf_out,
    input  logic             puf_all_done,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [PUF_W-1:0] resp_data,
    output logic [PUF_W-1:0] resp_unstable,
    output logic             resp_timeout
);

    localparam int EW = $clog2(NUM_EVALS + 1);
`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [EW-1:0] EVALS = EW'(NUM_EVALS);
    localparam logic [EW-1:0] HALF  = EW'(NUM_EVALS / 2);
`else
    localparam logic [EW-1:0] EVALS = EW'(1);
`endif
    localparam logic [10:0] TMO = 11'(TIMEOUT_CYCLES);
    localparam logic [4:0]  RLX = 5'(RELAX_CYCLES);

    state_e             state_q, state_d;
    logic [PUF_W-1:0]   chal_q, chal_d;
    logic [9:0]         wait_q, wait_d;
    logic [3:0]         rel_q, rel_d;
    logic [EW-1:0]      evals_q, evals_d;
    logic               armed_q, armed_d;
    logic [PUF_W-1:0]   data_q, data_d;
    logic               tmo_q, tmo_d;
    logic               done_s;
    logic [10:0]        wait_inc;
    logic [4:0]         rel_inc;
    logic               sample;

    puf_sync2 u_done_sync (
        .clk    (clk),
        .rst_ni (computer_reset),
        .d_i    (puf_all_done),
        .q_o    (done_s)
    );

`ifdef PUF_MAJORITY_VOTE_EN
    logic [EW-1:0]    ones_q [PUF_W];
    logic [EW-1:0]    ones_d [PUF_W];
    logic [PUF_W-1:0] unst_q, unst_d;
    logic [PUF_W-1:0] vote_data, vote_unst;

    always_comb begin
        vote_data = '0;
        vote_unst = '0;
        for (int i = 0; i < PUF_W; i++) begin
            vote_data[i] = ones_q[i] > HALF;
            vote_unst[i] = (ones_q[i] != '0) && (ones_q[i] < EVALS);
        end
    end

    always_ff @(posedge clk) begin
        if (!computer_reset) begin
            ones_q <= '{default: '0};
            unst_q <= '0;
        end else begin
            ones_q <= ones_d;
            unst_q <= unst_d;
        end
    end

    assign resp_unstable = unst_q;
`else
    assign resp_unstable = '0;
`endif

    always_ff @(posedge clk) begin
        if (!computer_reset) begin
            state_q <= S_IDLE;
            chal_q  <= '0;
            wait_q  <= '0;
            rel_q   <= '0;
            evals_q <= '0;
            armed_q <= 1'b0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            wait_q  <= wait_d;
            rel_q   <= rel_d;
            evals_q <= evals_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    assign wait_inc = {1'b0, wait_q} + 11'd1;
    assign rel_inc  = {1'b0, rel_q} + 5'd1;
    // A done already high on RUN entry is stale; require a low first.
    assign sample   = done_s && armed_q;

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        wait_d  = wait_q;
        rel_d   = rel_q;
        evals_d = evals_q;
        armed_d = armed_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
`ifdef PUF_MAJORITY_VOTE_EN
        ones_d  = ones_q;
        unst_d  = unst_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    chal_d  = req_challenge;
                    wait_d  = '0;
                    evals_d = '0;
                    armed_d = 1'b0;
                    data_d  = '0;
                    tmo_d   = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
                    ones_d  = '{default: '0};
                    unst_d  = '0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wait_d = wait_inc[9:0];
                if (!done_s) armed_d = 1'b1;
                if (sample) begin
`ifdef PUF_MAJORITY_VOTE_EN
                    for (int i = 0; i < PUF_W; i++) begin
                        if (puf_out[i] && ones_q[i] < EVALS)
                            ones_d[i] = ones_q[i] + EW'(1);
                    end
`else
                    data_d = puf_out;
`endif
                    evals_d = evals_q + EW'(1);
                    rel_d   = '0;
                    state_d = S_RELAX;
                end else if (wait_inc >= TMO) begin
                    tmo_d   = 1'b1;
                    data_d  = '0;
`ifdef PUF_MAJORITY_VOTE_EN
                    unst_d  = '0;
`endif
                    state_d = S_RESP;
                end
            end
            S_RELAX: begin
                if (!rel_inc[4]) rel_d = rel_inc[3:0];
                if (!done_s && rel_inc >= RLX) begin
                    if (evals_q < EVALS) begin
                        wait_d  = '0;
                        armed_d = 1'b0;
                        state_d = S_RUN;
                    end else begin
`ifdef PUF_MAJORITY_VOTE_EN
                        data_d = vote_data;
                        unst_d = vote_unst;
`endif
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready     = (state_q == S_IDLE) && computer_reset;
    assign puf_enable    = (state_q == S_RUN);
    assign puf_challenge = chal_q;
    assign resp_valid    = (state_q == S_RESP);
    assign resp_data     = data_q;
    assign resp_timeout  = tmo_q;

endmodule

// File: doc/puf_eval_controller.md
PUF_EVAL_CONTROLLER -- requirements
Module: puf_eval_controller

Interface
REQ-001 SHALL have parameter NUM_EVALS, default 5, evaluations per challenge (odd, 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles waiting for done per evaluation (1..1023).
REQ-003 SHALL have parameter RELAX_CYCLES, default 4, minimum enable-low cycles between evaluations (1..15).
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  clock, rising edge.
REQ-006 computer_reset  input  1  synchronous reset, active-low.
REQ-007 req_valid  input  1  challenge request valid.
REQ-008 req_ready  output  1  controller can accept a challenge.
REQ-009 req_challenge  input  8  challenge to evaluate.
REQ-010 puf_enable  output  1  enable to the parallel PUF array.
REQ-011 puf_challenge  output  8  challenge to the PUF array, held stable for the whole request.
REQ-012 puf_out  input  8  raw PUF response (asynchronous).
REQ-013 puf_all_done  input  1  PUF array completion (asynchronous).
REQ-014 resp_valid  output  1  response available.
REQ-015 resp_ready  input  1  consumer accepts response.
REQ-016 resp_data  output  8  voted response.
REQ-017 resp_unstable  output  8  per-bit flag, evaluations disagreed.
REQ-018 resp_timeout  output  1  request aborted on timeout.

Function
REQ-019 puf_all_done SHALL pass through a 2-flop synchronizer; done_s is its output; puf_out SHALL be sampled only in the cycle done_s first reads 1 within an evaluation.
REQ-020 States SHALL be IDLE, RUN, RELAX, RESP.
REQ-021 IDLE: req_ready=1; on req_valid&req_ready, latch req_challenge into puf_challenge, clear ones counters and eval count, go RUN next cycle.
REQ-022 RUN: puf_enable=1; wait counter increments each cycle; on done_s=1 sample puf_out, add each bit to its per-bit ones counter, increment eval count, go RELAX.
REQ-023 RUN: if wait counter reaches TIMEOUT_CYCLES with done_s=0, go RESP with resp_timeout=1, resp_data=0, resp_unstable=0; puf_enable drops the same cycle.
REQ-024 RELAX: puf_enable=0; leave only when done_s=0 and at least RELAX_CYCLES cycles elapsed; go RUN if eval count < NUM_EVALS, else RESP.
REQ-025 Vote: resp_data[i]=1 iff ones[i] > NUM_EVALS/2 (integer division); resp_unstable[i]=1 iff 0 < ones[i] < NUM_EVALS.
REQ-026 RESP: resp_valid=1, outputs held stable until resp_valid&resp_ready, then go IDLE next cycle.
REQ-027 req_ready SHALL be 0 in every state except IDLE; requests arriving outside IDLE are not accepted.
REQ-028 puf_enable SHALL never be 1 outside RUN.
REQ-029 Ones counters SHALL be ceil(log2(NUM_EVALS+1)) bits wide and never wrap.
REQ-030 done_s already 1 on RUN entry (stale) SHALL not be sampled; RELAX guarantees done_s=0 before re-entering RUN.

Reset
REQ-031 computer_reset=0 at a clock edge SHALL force IDLE and clear all counters, from any state, including mid-evaluation.
REQ-032 Reset values: req_ready=0 during reset then 1 in IDLE, puf_enable=0, puf_challenge=0, resp_valid=0, resp_data=0, resp_unstable=0, resp_timeout=0, synchronizer flops=0.

Configuration
REQ-033 Macro PUF_MAJORITY_VOTE_EN defined: behaviour per REQ-022..REQ-025 with NUM_EVALS evaluations.
REQ-034 Macro undefined: exactly one evaluation per request regardless of NUM_EVALS; resp_data=sampled puf_out; resp_unstable tied to 0; no ones counters instantiated.

Structure
REQ-035 State encoding typedef, and default constants for NUM_EVALS, TIMEOUT_CYCLES, RELAX_CYCLES SHALL live in shared package puf_pkg.
REQ-036 The 2-flop synchronizer SHALL be sub-module puf_sync2, reused for puf_all_done.

Verification
REQ-037 Single request, challenge 0xA5, model returns 0x3C each eval, done after 10 cycles -> resp_data=0x3C, resp_unstable=0x00, 5 enable pulses.
REQ-038 Model returns 0x01,0x01,0x00,0x01,0x00 -> resp_data=0x01, resp_unstable=0x01.
REQ-039 Done never asserts, TIMEOUT_CYCLES=20 -> resp_timeout=1, resp_data=0 within 23 cycles of RUN entry, puf_enable=0.
REQ-040 resp_ready held 0 for 8 cycles -> resp_valid and resp_data stable; req_ready=0 throughout; new req_valid ignored.
REQ-041 computer_reset=0 during third evaluation -> next cycle puf_enable=0, req_ready=1 after release, following request votes fresh.
REQ-042 Build without PUF_MAJORITY_VOTE_EN, challenge 0x5A, model returns 0x81 -> one enable pulse, resp_data=0x81, resp_unstable=0.
